// File: rtl/sonar_scan_controller.sv
// Round-robin HC-SR04 style ranging controller: fires one sensor at a time, times its echo,
// converts to centimetres with round-half-up and flags per-channel timeouts.
module sonar_scan_controller #(
    parameter int unsigned N_CH          = 3,
    parameter int unsigned DIST_W        = 9,
    parameter int unsigned CYCLES_PER_CM = 2941,
    parameter int unsigned TRIG_CYC      = 500,
    parameter int unsigned ECHO_WAIT_CYC = 1_000_000,
    parameter int unsigned ECHO_MAX_CYC  = 1_500_000,
    parameter int unsigned GAP_CYC       = 3_000_000
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     iniciar,
    input  logic [N_CH-1:0]          echo,
    output logic [N_CH-1:0]          trigger,
    output logic [N_CH*DIST_W-1:0]   distancia,
    output logic [N_CH-1:0]          timeout,
    output logic                     pronto,
    output logic                     ocupado,
    output logic [2:0]               db_canal,
    output logic [3:0]               db_estado
);

    localparam int unsigned REM_W = $clog2(CYCLES_PER_CM + 1);

    typedef enum logic [3:0] {
        StIdle     = 4'd0,
        StTrig     = 4'd1,
        StWaitEcho = 4'd2,
        StMeasure  = 4'd3,
        StStore    = 4'd4,
        StGap      = 4'd5,
        StDone     = 4'd6
    } state_e;

    state_e                   state_q, state_d;
    logic [2:0]               ch_q, ch_d;
    logic [31:0]              timer_q, timer_d;
    logic [REM_W-1:0]         rem_q, rem_d;
    logic [DIST_W-1:0]        cm_q, cm_d;
    logic [N_CH*DIST_W-1:0]   dist_q, dist_d;
    logic [N_CH-1:0]          tout_q, tout_d;
    logic [N_CH-1:0]          trig_q, trig_d;
    logic [N_CH-1:0]          echo_meta_q, echo_sync_q, echo_prev_q;
    logic                     iniciar_q;

    logic                     echo_cur, echo_last, echo_rise, echo_fall;
    logic                     load_timeout, load_store;
    logic [DIST_W:0]          sum_round;
    logic [DIST_W-1:0]        stored;

    always_comb begin
        echo_cur  = 1'b0;
        echo_last = 1'b0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == 3'(i)) begin
                echo_cur  = echo_sync_q[i];
                echo_last = echo_prev_q[i];
            end
        end
    end

    assign echo_rise = echo_cur & ~echo_last;
    assign echo_fall = ~echo_cur & echo_last;

    // Round half up, then clamp if the increment carried past the top code.
    assign sum_round = {1'b0, cm_q}
                     + {{DIST_W{1'b0}}, (rem_q >= REM_W'(CYCLES_PER_CM / 2))};
    assign stored    = sum_round[DIST_W] ? '1 : sum_round[DIST_W-1:0];

    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        rem_d        = rem_q;
        cm_d         = cm_q;
        dist_d       = dist_q;
        tout_d       = tout_q;
        pronto       = 1'b0;
        load_timeout = 1'b0;
        load_store   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iniciar && !iniciar_q) begin
                    ch_d    = 3'd0;
                    state_d = StTrig;
                end
            end
            StTrig: begin
                if (timer_q == TRIG_CYC - 1) state_d = StWaitEcho;
            end
            StWaitEcho: begin
                if (echo_rise) begin
                    rem_d   = '0;
                    cm_d    = '0;
                    state_d = StMeasure;
                end else if (timer_q == ECHO_WAIT_CYC - 1) begin
                    load_timeout = 1'b1;
                    state_d      = StGap;
                end
            end
            StMeasure: begin
                if (echo_fall) begin
                    state_d = StStore;
                end else if (timer_q == ECHO_MAX_CYC - 1) begin
                    load_timeout = 1'b1;
                    state_d      = StGap;
                end else if (echo_cur) begin
                    if (rem_q == REM_W'(CYCLES_PER_CM - 1)) begin
                        rem_d = '0;
                        if (cm_q != '1) cm_d = cm_q + 1'b1;
                    end else begin
                        rem_d = rem_q + 1'b1;
                    end
                end
            end
            StStore: begin
                load_store = 1'b1;
                state_d    = StGap;
            end
            StGap: begin
                if (timer_q == GAP_CYC - 1) begin
                    if (ch_q < 3'(N_CH - 1)) begin
                        ch_d    = ch_q + 3'd1;
                        state_d = StTrig;
                    end else begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                pronto = 1'b1;
                if (iniciar) begin
                    ch_d    = 3'd0;
                    state_d = StTrig;
                end else begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase

        // Only the active channel's result is ever touched.
        for (int i = 0; i < int'(N_CH); i++) begin
            if (ch_q == 3'(i)) begin
                if (load_timeout) begin
                    dist_d[i*DIST_W +: DIST_W] = '1;
                    tout_d[i]                  = 1'b1;
                end
                if (load_store) begin
                    dist_d[i*DIST_W +: DIST_W] = stored;
                    tout_d[i]                  = 1'b0;
                end
            end
        end

        for (int i = 0; i < int'(N_CH); i++) begin
            trig_d[i] = (state_d == StTrig) && (ch_d == 3'(i));
        end

        if (state_d != state_q || state_q == StIdle) timer_d = '0;
        else                                         timer_d = timer_q + 32'd1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            ch_q        <= '0;
            timer_q     <= '0;
            rem_q       <= '0;
            cm_q        <= '0;
            dist_q      <= '0;
            tout_q      <= '0;
            trig_q      <= '0;
            echo_meta_q <= '0;
            echo_sync_q <= '0;
            echo_prev_q <= '0;
            iniciar_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_q        <= ch_d;
            timer_q     <= timer_d;
            rem_q       <= rem_d;
            cm_q        <= cm_d;
            dist_q      <= dist_d;
            tout_q      <= tout_d;
            trig_q      <= trig_d;
            echo_meta_q <= echo;
            echo_sync_q <= echo_meta_q;
            echo_prev_q <= echo_sync_q;
            iniciar_q   <= iniciar;
        end
    end

    assign trigger   = trig_q;
    assign distancia = dist_q;
    assign timeout   = tout_q;
    assign ocupado   = (state_q != StIdle) && (state_q != StDone);
    assign db_canal  = ch_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_sonar_scan_controller.sv
// Bench for sonar_scan_controller with shortened timing: an echo responder answers each trigger
// fall, and results are compared to a round-half-up reference computed from echo widths.
module tb_sonar_scan_controller;

    localparam int N_CH   = 3;
    localparam int DIST_W = 6;
    localparam int CPC    = 10;
    localparam int TRIG   = 5;
    localparam int EWAIT  = 60;
    localparam int EMAX   = 700;
    localparam int GAP    = 20;
    localparam int DMAX   = (1 << DIST_W) - 1;

    logic                   clock = 1'b0;
    logic                   reset;
    logic                   iniciar;
    logic [N_CH-1:0]        echo;
    logic [N_CH-1:0]        trigger;
    logic [N_CH*DIST_W-1:0] distancia;
    logic [N_CH-1:0]        timeout;
    logic                   pronto;
    logic                   ocupado;
    logic [2:0]             db_canal;
    logic [3:0]             db_estado;

    int vectors     = 0;
    int miscompares = 0;

    int resp_width[N_CH];
    int resp_delay[N_CH];
    bit resp_en[N_CH];

    int trig_ch_q[$];
    int trig_len_q[$];
    int pronto_cnt = 0;
    bit multi_hot  = 1'b0;

    always #10 clock = ~clock;

    sonar_scan_controller #(
        .N_CH         (N_CH),
        .DIST_W       (DIST_W),
        .CYCLES_PER_CM(CPC),
        .TRIG_CYC     (TRIG),
        .ECHO_WAIT_CYC(EWAIT),
        .ECHO_MAX_CYC (EMAX),
        .GAP_CYC      (GAP)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .iniciar  (iniciar),
        .echo     (echo),
        .trigger  (trigger),
        .distancia(distancia),
        .timeout  (timeout),
        .pronto   (pronto),
        .ocupado  (ocupado),
        .db_canal (db_canal),
        .db_estado(db_estado)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Reference: echo high W cycles; the rise-detect cycle is not counted, so W-1 cycles
    // are converted to cm, rounded half up, clamped. Missing or over-long echo reads all-ones.
    function automatic int exp_dist(input int k);
        int h, d;
        if (!resp_en[k] || resp_width[k] > EMAX) return DMAX;
        h = resp_width[k] - 1;
        d = (2 * h + CPC) / (2 * CPC);
        return (d > DMAX) ? DMAX : d;
    endfunction

    function automatic logic [N_CH-1:0] exp_tout();
        logic [N_CH-1:0] t;
        for (int k = 0; k < N_CH; k++) t[k] = !resp_en[k] || resp_width[k] > EMAX;
        return t;
    endfunction

    task automatic wait_pronto(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (pronto === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_pronto_seen"}, 64'(seen), 64'd1);
    endtask

    task automatic wait_state(input int st, input int ch, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            tick();
            if (db_estado === 4'(st) && db_canal === 3'(ch)) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_state_reached"}, 64'(seen), 64'd1);
    endtask

    task automatic check_results(input string tag);
        for (int k = 0; k < N_CH; k++)
            check($sformatf("%s_dist%0d", tag, k), 64'(distancia[k*DIST_W +: DIST_W]),
                  64'(exp_dist(k)));
        check({tag, "_timeout"}, 64'(timeout), 64'(exp_tout()));
    endtask

    task automatic run_and_check(input string tag);
        trig_ch_q.delete();
        trig_len_q.delete();
        iniciar = 1'b1;
        tick(2);
        iniciar = 1'b0;
        wait_pronto(tag);
        check({tag, "_ocupado_at_pronto"}, 64'(ocupado), 64'd0);
        check_results(tag);
        check({tag, "_trig_count"}, 64'(trig_ch_q.size()), 64'(N_CH));
        for (int i = 0; i < N_CH; i++) begin
            if (trig_ch_q.size() > i) begin
                check($sformatf("%s_trig_order%0d", tag, i), 64'(trig_ch_q[i]), 64'(i));
                check($sformatf("%s_trig_len%0d", tag, i), 64'(trig_len_q[i]), 64'(TRIG));
            end
        end
        tick();
        check({tag, "_idle_after"}, 64'(db_estado), 64'd0);
    endtask

    task automatic set_all(input int w);
        for (int k = 0; k < N_CH; k++) begin
            resp_en[k]    = 1'b1;
            resp_width[k] = w;
            resp_delay[k] = 3;
        end
    endtask

    // Echo responder: after a trigger falls, wait resp_delay then hold echo for resp_width.
    initial begin
        logic [N_CH-1:0] trig_prev = '0;
        int r_state = 0;
        int r_ch    = 0;
        int r_cnt   = 0;
        echo = '0;
        forever begin
            @(posedge clock);
            #1;
            for (int k = 0; k < N_CH; k++) begin
                if (r_state == 0 && trig_prev[k] && !trigger[k] && resp_en[k]) begin
                    r_ch    = k;
                    r_cnt   = resp_delay[k];
                    r_state = 1;
                end
            end
            if (r_state == 1) begin
                if (r_cnt == 0) begin
                    echo[r_ch] = 1'b1;
                    r_cnt      = resp_width[r_ch];
                    r_state    = 2;
                end else begin
                    r_cnt--;
                end
            end else if (r_state == 2) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    echo[r_ch] = 1'b0;
                    r_state    = 0;
                end
            end
            trig_prev = trigger;
        end
    end

    // Trigger pulse recorder and pronto counter.
    initial begin
        int cur = -1;
        int len = 0;
        forever begin
            @(posedge clock);
            #1;
            if ($countones(trigger) > 1) multi_hot = 1'b1;
            if (pronto === 1'b1) pronto_cnt++;
            if (trigger != '0) begin
                if (cur < 0) begin
                    for (int k = 0; k < N_CH; k++) if (trigger[k]) cur = k;
                    len = 0;
                end
                len++;
            end else if (cur >= 0) begin
                trig_ch_q.push_back(cur);
                trig_len_q.push_back(len);
                cur = -1;
            end
        end
    end

    initial begin
        reset   = 1'b0;
        iniciar = 1'b0;
        set_all(301);
        tick(3);
        check("rst_trigger", 64'(trigger), 64'd0);
        check("rst_dist", 64'(distancia), 64'd0);
        check("rst_timeout", 64'(timeout), 64'd0);
        check("rst_pronto", 64'(pronto), 64'd0);
        check("rst_ocupado", 64'(ocupado), 64'd0);
        check("rst_canal", 64'(db_canal), 64'd0);
        check("rst_estado", 64'(db_estado), 64'd0);
        reset = 1'b1;
        tick(2);
        check("post_rst_estado", 64'(db_estado), 64'd0);

        // Basic sweep, all channels answer.
        set_all(301);
        pronto_cnt = 0;
        run_and_check("basic");
        tick(50);
        check("basic_single_pronto", 64'(pronto_cnt), 64'd1);

        // Rounding boundaries.
        set_all(46);
        resp_width[1] = 45;
        resp_width[2] = 50;
        run_and_check("round_a");
        resp_width[0] = 1;
        resp_width[1] = 41;
        resp_width[2] = 16;
        run_and_check("round_b");

        // Channel 1 silent.
        set_all(301);
        resp_en[1] = 1'b0;
        run_and_check("no_echo_ch1");

        // Over-long echo on 0, exact limit on 1, one past limit on 2.
        set_all(301);
        resp_width[0] = 710;
        resp_width[1] = 700;
        resp_width[2] = 701;
        run_and_check("long_echo");

        // Randomized sweeps.
        for (int r = 0; r < 6; r++) begin
            for (int k = 0; k < N_CH; k++) begin
                resp_en[k]    = ($urandom_range(0, 7) != 0);
                resp_width[k] = $urandom_range(1, EMAX);
                resp_delay[k] = $urandom_range(0, 10);
            end
            run_and_check($sformatf("rand%0d", r));
        end

        // Continuous mode with a retoggle during the first sweep.
        set_all(101);
        pronto_cnt = 0;
        trig_ch_q.delete();
        trig_len_q.delete();
        iniciar = 1'b1;
        wait_state(1, 1, "cont_mid1");
        iniciar = 1'b0;
        tick(3);
        iniciar = 1'b1;
        wait_pronto("cont1");
        check("cont1_trig_count", 64'(trig_ch_q.size()), 64'(N_CH));
        tick();
        check("cont2_start_estado", 64'(db_estado), 64'd1);
        check("cont2_start_trigger", 64'(trigger), 64'd1);
        check("cont2_start_ocupado", 64'(ocupado), 64'd1);
        wait_state(1, 1, "cont_mid2");
        iniciar = 1'b0;
        wait_pronto("cont2");
        check_results("cont2");
        tick(2500);
        check("cont_pronto_count", 64'(pronto_cnt), 64'd2);
        check("cont_idle", 64'(db_estado), 64'd0);

        // Reset during measurement on channel 1.
        set_all(301);
        iniciar = 1'b1;
        tick(2);
        iniciar = 1'b0;
        wait_state(3, 1, "mid_rst");
        tick(5);
        check("mid_rst_pre_dist0", 64'(distancia[0 +: DIST_W]), 64'(exp_dist(0)));
        reset = 1'b0;
        #1;
        check("mid_rst_trigger", 64'(trigger), 64'd0);
        check("mid_rst_dist", 64'(distancia), 64'd0);
        check("mid_rst_ocupado", 64'(ocupado), 64'd0);
        check("mid_rst_estado", 64'(db_estado), 64'd0);
        check("mid_rst_canal", 64'(db_canal), 64'd0);
        tick(400);
        reset = 1'b1;
        tick(2);
        run_and_check("after_rst");

        check("trigger_one_hot", 64'(multi_hot), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sonar_scan_controller.md
Name: sonar_scan_controller

Overview:
- Parametrised N-channel ultrasonic (HC-SR04 style) ranging controller for the water-level system; successor to the fixed three-sensor front end.
- Fires sensors one at a time in round-robin order, measures each echo pulse, converts it to centimetres with round-half-up, and flags timeouts per channel.
- Publishes one distance word per channel plus a sweep-complete pulse.
- Supports single-sweep and continuous modes.
- Sits between the sensor pins and the level/valve/buzzer control FSM.

Parameters:
N_CH, 3, number of sensor channels (1..8)
DIST_W, 9, distance width in cm; results saturate at 2^DIST_W-1
CYCLES_PER_CM, 2941, clock cycles per cm of echo (58.82 us at 50 MHz)
TRIG_CYC, 500, trigger high time in cycles (10 us)
ECHO_WAIT_CYC, 1_000_000, max cycles from trigger fall to echo rise (20 ms)
ECHO_MAX_CYC, 1_500_000, max echo high time in cycles (30 ms)
GAP_CYC, 3_000_000, quiet time after each channel before the next trigger (60 ms)

Ports:
clock  in  1  system clock, 50 MHz
reset  in  1  asynchronous, active-low; clears all state
iniciar  in  1  level; rising edge starts a sweep; held high enables continuous mode
echo  in  N_CH  raw echo inputs, asynchronous
trigger  out  N_CH  per-channel trigger pulses, registered
distancia  out  N_CH*DIST_W  channel k at bits [k*DIST_W +: DIST_W]
timeout  out  N_CH  per-channel timeout flag from the last measurement
pronto  out  1  one-cycle pulse when a sweep completes
ocupado  out  1  high while a sweep is in progress
db_canal  out  3  index of the active channel
db_estado  out  4  FSM state code

Behaviour:
- Reset (reset=0, asynchronous): trigger=0, distancia=0, timeout=0, pronto=0, ocupado=0, db_canal=0, FSM=IDLE. All counters and synchroniser flops clear.
- echo passes through a 2-FF synchroniser per channel. Only the active channel's synchronised echo is used. Edges are detected on the synchronised signal.
- State codes: IDLE=0, TRIG=1, WAIT_ECHO=2, MEASURE=3, STORE=4, GAP=5, DONE=6.
- IDLE: on the rising edge of iniciar (registered compare), set ch=0, ocupado=1, go to TRIG.
- TRIG: trigger[ch]=1 for exactly TRIG_CYC cycles. All other trigger bits stay 0. Then go to WAIT_ECHO.
- WAIT_ECHO: wait for a rising edge of sync echo[ch].
  - Edge seen: clear cm and remainder counters, go to MEASURE.
  - ECHO_WAIT_CYC cycles elapse with no edge: set timeout[ch]=1, load distancia[ch] with all-ones, go to GAP.
- MEASURE: every cycle with echo high, increment the remainder counter. When remainder reaches CYCLES_PER_CM-1, wrap it to 0 and increment cm (saturating at 2^DIST_W-1).
  - Falling edge of echo: go to STORE.
  - Echo high longer than ECHO_MAX_CYC: timeout[ch]=1, distancia[ch]=all-ones, go to GAP.
- STORE (1 cycle): distancia[ch] = cm + (remainder >= CYCLES_PER_CM/2 ? 1 : 0), saturated. Set timeout[ch]=0. Go to GAP.
- GAP: wait GAP_CYC cycles.
  - If ch < N_CH-1: ch++, go to TRIG.
  - Else: go to DONE.
- DONE (1 cycle): pronto=1, ocupado=0.
  - If iniciar is still high, set ch=0 and go to TRIG (continuous mode). A new rising edge is not required.
  - Otherwise go to IDLE.
- A channel's distancia/timeout changes only in STORE or on that channel's timeout. All other channels hold their values, so a host may read mid-sweep.
- Edges on iniciar during a sweep are ignored; no queueing. Dropping iniciar mid-sweep lets the current sweep finish and then return to IDLE.
- Echo already high at entry to WAIT_ECHO: wait for a genuine rising edge.
- Echo rising during TRIG: ignored.
- Reset asserted mid-sweep: all outputs return to reset values immediately. No partial results are kept.
- Measurement latency: STORE occurs 3 cycles after the raw echo falls (2 synchroniser cycles + 1 edge-detect cycle).

Test Plan:
1. Reset, iniciar 0→1; the bench answers each trigger 400 us later with a 4353 us echo on all channels. Required: trigger pulses of 10 us in order 0,1,2; distancia=74 on each channel; timeout=000; one pronto pulse; ocupado falls with pronto.
2. Echo 5899 us (100.29 cm) → 100 (round down). Echo 5882 us → 100. Echo 4399 us (74.79 cm) → 75 (round up).
3. Channel 1 never echoes; other channels get 4353 us. Required: channel 1 reads 511 with timeout=010, channels 0 and 2 read 74, and pronto still pulses after channel 2.
4. Echo held high beyond 30 ms on channel 0. Required: channel 0 reads 511 with timeout[0]=1; the sweep continues to channel 1.
5. iniciar held high across two sweeps. Required: the second sweep starts the cycle after the first pronto; exactly two pronto pulses when iniciar falls during sweep 2; an iniciar retoggle during sweep 1 has no effect.
6. reset driven low during MEASURE on channel 1. Required: same cycle trigger=0, distancia=0, ocupado=0, db_estado=0. After release, the next iniciar edge restarts at channel 0.
